uart_rx_async: RTL
==================

Name: uart_rx_async

Overview:
- Asynchronous USART receiver that directly consumes the baud generator's 16x oversampling strobe.
- Detects start bits, majority-samples each bit, and assembles 8- or 9-bit frames.
- Pushes completed frames, with per-frame FERR and RX9D, into a 2-deep receive FIFO; the CPU reads the FIFO through the RCREG/RCSTA special-function-register path.
- Raises RCIF while data is pending and OERR on overrun.

Parameters:
- SYNC_STAGES, 2, number of flops synchronising rx_in to clk (minimum 2).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- spen  in  1  serial port enable (RCSTA.SPEN); 0 holds receiver and FIFO in reset
- cren  in  1  continuous receive enable (RCSTA.CREN)
- rx9  in  1  1 = 9-bit frames
- rx_in  in  1  RX pin, asynchronous
- rx_div16_en  in  1  one-clk strobe, 16 per bit period, from baud generator
- rcreg_rd_en  in  1  one-clk CPU read of RCREG; pops FIFO head
- rcreg_out  out  8  FIFO head data
- rx9d_out  out  1  FIFO head 9th bit
- ferr_out  out  1  FIFO head framing error
- oerr_out  out  1  overrun error, sticky
- rcif_out  out  1  FIFO non-empty
- rx_busy  out  1  FSM not in IDLE

Behaviour:
- **Reset** (rst=1, or spen=0): FSM=IDLE, tick counter=0, shift register=0, FIFO empty, oerr=0.
  - All outputs are 0, except rcreg_out, rx9d_out and ferr_out, which show the empty head entry (all 0).
  - Reset mid-frame discards the partial frame.
- **Synchroniser**: rx_in passes through SYNC_STAGES flops to give rxs; synchroniser flops reset to 1. All sampling uses rxs.
- **Tick counter**: 4 bits, advances only on rx_div16_en.
- **FSM states**: IDLE, START, DATA, STOP.
- **IDLE**
  - Leaves IDLE only when cren=1, oerr=0, and rxs=0 on an rx_div16_en cycle. It then enters START with tick counter=0.
  - cren=0 forces IDLE from any state within 1 clk and clears oerr. FIFO contents are retained.
- **Majority sampling**: in every state except IDLE, rxs is captured on ticks 7, 8 and 9. The bit value is the majority of the three samples.
- **START**
  - At tick 9: majority=1 means a false start, so go to IDLE with no push.
  - At tick 9: majority=0 keeps the start and the FSM waits for tick 15.
  - At tick 15, go to DATA with bit index=0 and counter wrapping to 0.
- **DATA**
  - At tick 9, the majority bit is shifted in LSB-first.
  - At tick 15, the bit index increments. After index 7 (or 8 when rx9=1), go to STOP.
  - rx9 is sampled at start acceptance and held for the frame.
- **STOP**
  - At tick 9, the frame {ferr = ~majority, rx9d, data[7:0]} is pushed and the FSM returns to IDLE in the same clk.
  - This allows back-to-back frames, whose next start can be detected from the following tick.
  - A stop bit sampled as 0 still pushes, with ferr=1.
- **FIFO**: 2 entries × 10 bits {ferr, rx9d, data}.
  - Head entry drives rcreg_out, rx9d_out and ferr_out combinationally from FIFO storage.
  - rcif_out = count != 0.
- **Push latency**: the push is registered on the clk edge ending the stop tick-9 cycle. rcif_out is high the following cycle.
- **Pop**: rcreg_rd_en with count>0 removes the head on the next edge; the second entry becomes head. Pop on empty is ignored and has no side effect.
- **Simultaneous push and pop**:
  - count=2: pop then push; no overrun, count stays 2.
  - count=1: count stays 1 and the head becomes the new frame.
  - count=0: the push is accepted and the pop is ignored.
- **Overrun**: a push with count=2 and no simultaneous pop drops the frame and sets oerr=1.
  - While oerr=1, IDLE does not accept starts.
  - FIFO remains readable.
  - oerr clears only on cren=0, spen=0 or rst.
- rx_div16_en pulses arriving while rst=1 are ignored.

Test Plan:
- **Basic 8-bit frame**: rx_div16_en every 4 clk (64 clk/bit); send 0xA5 with stop=1 → rcif=1, rcreg_out=0xA5, ferr=0, rx9d=0; pop → rcif=0.
- **9-bit and framing error**: rx9=1; send data 0x3C, 9th bit=1, stop=0 → rcreg_out=0x3C, rx9d_out=1, ferr_out=1.
- **Glitch rejection**: rxs low for 5 ticks (ticks 0–4), then high → no push; rx_busy returns to 0 after tick 9; a subsequent 0x55 frame is received correctly.
- **Overrun**: send 0x11, 0x22, 0x33 with no reads → oerr=1, FIFO holds 0x11 then 0x22; a fourth frame is ignored; pulse cren=0 → oerr=0, FIFO still 0x11/0x22; cren=1, send 0x44 → received.
- **Boundary, pop with push**: FIFO holds 0x11/0x22; assert rcreg_rd_en exactly on the 0x33 push edge → oerr=0, FIFO = 0x22/0x33.
- **Reset mid-frame**: assert rst during DATA bit 4 of a frame, release → rcif=0, oerr=0, rx_busy=0; the next full 0x81 frame is received correctly.

Source files
------------

// File: rtl/uart_rx_async_if.sv
// Receiver-side signal bundle. The master drives line, strobe and control.
// The slave (the receiver) returns the FIFO head and the status flags.
interface uart_rx_async_if;
    logic       spen;
    logic       cren;
    logic       rx9;
    logic       rx_in;
    logic       rx_div16_en;
    logic       rcreg_rd_en;
    logic [7:0] rcreg_out;
    logic       rx9d_out;
    logic       ferr_out;
    logic       oerr_out;
    logic       rcif_out;
    logic       rx_busy;

    modport master (
        output spen, cren, rx9, rx_in, rx_div16_en, rcreg_rd_en,
        input  rcreg_out, rx9d_out, ferr_out, oerr_out, rcif_out, rx_busy
    );

    modport slave (
        input  spen, cren, rx9, rx_in, rx_div16_en, rcreg_rd_en,
        output rcreg_out, rx9d_out, ferr_out, oerr_out, rcif_out, rx_busy
    );
endinterface

// File: rtl/uart_rx_async.sv
// Asynchronous USART receiver driven by a 16x oversampling strobe.
// Majority-votes ticks 7/8/9 of each bit and queues frames in a 2-deep FIFO.
module uart_rx_async #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic             clk,
    input logic             rst,
    uart_rx_async_if.slave  rx_if
);
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    // spen=0 behaves exactly like rst
    logic clr;
    assign clr = rst | ~rx_if.spen;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    assign rxs = sync_q[SYNC_STAGES-1];

    state_e     state_q, state_d;
    logic [3:0] tick_q, tick_d, tick_nxt;
    logic [3:0] idx_q, idx_d;
    logic [8:0] shift_q, shift_d;
    logic [1:0] samp_q, samp_d;
    logic       rx9_q, rx9_d;
    logic       maj;
    logic       push;
    logic [9:0] push_data;

    logic [9:0] head_q, tail_q;
    logic [1:0] cnt_q;
    logic       oerr_q;
    logic       pop;

    // Line synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (clr) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_if.rx_in};
        end
    end

    // Receiver FSM and datapath registers
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StIdle;
            tick_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            samp_q  <= '0;
            rx9_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            samp_q  <= samp_d;
            rx9_q   <= rx9_d;
        end
    end

    assign tick_nxt = tick_q + 4'd1;
    // Third vote is the live sample on tick 9
    assign maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);

    // Next-state: the start-detect strobe counts as tick 0 of the start bit
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        samp_d    = samp_q;
        rx9_d     = rx9_q;
        push      = 1'b0;
        push_data = '0;
        if (rx_if.rx_div16_en) begin
            unique case (state_q)
                StIdle: begin
                    if (rx_if.cren && !oerr_q && !rxs) begin
                        state_d = StStart;
                        tick_d  = '0;
                        shift_d = '0;
                        rx9_d   = rx_if.rx9;
                    end
                end
                StStart: begin
                    tick_d = tick_nxt;
                    if (tick_nxt == 4'd9 && maj) begin
                        state_d = StIdle;
                    end else if (tick_nxt == 4'd15) begin
                        state_d = StData;
                        idx_d   = '0;
                    end
                end
                StData: begin
                    tick_d = tick_nxt;
                    if (tick_nxt == 4'd9) begin
                        shift_d[idx_q] = maj;
                    end else if (tick_nxt == 4'd15) begin
                        if (idx_q == (rx9_q ? 4'd8 : 4'd7)) begin
                            state_d = StStop;
                        end else begin
                            idx_d = idx_q + 4'd1;
                        end
                    end
                end
                StStop: begin
                    tick_d = tick_nxt;
                    if (tick_nxt == 4'd9) begin
                        push      = 1'b1;
                        push_data = {~maj, rx9_q & shift_q[8], shift_q[7:0]};
                        state_d   = StIdle;
                    end
                end
            endcase
            if (state_q != StIdle) begin
                if (tick_nxt == 4'd7) samp_d[0] = rxs;
                if (tick_nxt == 4'd8) samp_d[1] = rxs;
            end
        end
        if (!rx_if.cren) begin
            state_d = StIdle;
            push    = 1'b0;
        end
    end

    assign pop = rx_if.rcreg_rd_en && (cnt_q != 2'd0);

    // Two-entry FIFO plus sticky overrun; vacated slots are zeroed
    always_ff @(posedge clk) begin
        if (clr) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            oerr_q <= 1'b0;
        end else begin
            if (push && pop) begin
                if (cnt_q == 2'd2) begin
                    head_q <= tail_q;
                    tail_q <= push_data;
                end else begin
                    head_q <= push_data;
                end
            end else if (push) begin
                if (cnt_q == 2'd0) begin
                    head_q <= push_data;
                    cnt_q  <= 2'd1;
                end else if (cnt_q == 2'd1) begin
                    tail_q <= push_data;
                    cnt_q  <= 2'd2;
                end else begin
                    oerr_q <= 1'b1;
                end
            end else if (pop) begin
                head_q <= tail_q;
                tail_q <= '0;
                cnt_q  <= cnt_q - 2'd1;
            end
            if (!rx_if.cren) oerr_q <= 1'b0;
        end
    end

    assign rx_if.rcreg_out = head_q[7:0];
    assign rx_if.rx9d_out  = head_q[8];
    assign rx_if.ferr_out  = head_q[9];
    assign rx_if.oerr_out  = oerr_q;
    assign rx_if.rcif_out  = (cnt_q != 2'd0);
    assign rx_if.rx_busy   = (state_q != StIdle);
endmodule
